// File: rtl/jts16b_sndlatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jts16b_sndlatch: main->sound command FIFO with sound->main reply latch    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module jts16b_sndlatch #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       main_rd,
  output logic [7:0] main_dout,
  output logic [2:0] main_st,
  input  logic       snd_rd,
  input  logic       snd_wr,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_obf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

  // Strobe bit order: [3] main_wr, [2] main_rd, [1] snd_rd, [0] snd_wr
  logic [3:0]    strb;
  logic [3:0]    prev_q, arm_q;
  logic [3:0]    rise, fall;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full_q, full_d;
  logic          obf_q, obf_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rply_q, rply_d;
  logic          rfull_q, rfull_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign strb = {main_wr, main_rd, snd_rd, snd_wr};
  // A strobe must be seen low after reset before its edges count, so a
  // strobe held high across reset release produces neither rise nor fall.
  assign rise = strb & ~prev_q & arm_q;
  assign fall = ~strb & prev_q & arm_q;

  assign pop  = fall[1] && (cnt_q != '0);
  assign push = rise[3] && ((cnt_q != C_FULL) || pop);

  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d   = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d   = ovf_q | (rise[3] & ~push);
    full_d  = (cnt_q == C_FULL);
    obf_d   = (cnt_q != '0);
    // Once empty, the last popped byte stays visible to the sound CPU.
    dout_d  = (cnt_q != '0) ? mem_q[rptr_q] : dout_q;
    rply_d  = rise[0] ? snd_din : rply_q;
    rfull_d = rise[0] ? 1'b1 : (fall[2] ? 1'b0 : rfull_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      arm_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      obf_q   <= 1'b0;
      dout_q  <= 8'hff;
      rply_q  <= 8'hff;
      rfull_q <= 1'b0;
    end else begin
      prev_q  <= strb;
      arm_q   <= arm_q | ~strb;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      obf_q   <= obf_d;
      dout_q  <= dout_d;
      rply_q  <= rply_d;
      rfull_q <= rfull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= main_din;
    end
  end

  assign main_dout = rply_q;
  assign main_st   = {ovf_q, rfull_q, full_q};
  assign snd_dout  = dout_q;
  assign snd_obf   = obf_q;

endmodule
`default_nettype wire

// File: tb/tb_jts16b_sndlatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jts16b_sndlatch: scoreboard bench for the sound command latch          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_jts16b_sndlatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       main_wr = 1'b0, main_rd = 1'b0, snd_rd = 1'b0, snd_wr = 1'b0;
  logic [7:0] main_din = 8'h00, snd_din = 8'h00;
  logic [7:0] main_dout, snd_dout;
  logic [2:0] main_st;
  logic       snd_obf;

  int checks = 0;
  int failures = 0;
  logic [7:0] cmd_q[$];
  logic [7:0] rply_q[$];

  jts16b_sndlatch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
    .main_dout(main_dout), .main_st(main_st),
    .snd_rd(snd_rd), .snd_wr(snd_wr), .snd_din(snd_din),
    .snd_dout(snd_dout), .snd_obf(snd_obf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_cmd(input logic [7:0] b, input int hold, input bit accept);
    main_din = b;
    main_wr  = 1'b1;
    if (accept) cmd_q.push_back(b);
    cyc(hold);
    main_wr  = 1'b0;
    cyc(2);
  endtask

  task automatic rd_cmd(input int hold);
    snd_rd = 1'b1;
    cyc(hold);
    snd_rd = 1'b0;
    cyc(3);
  endtask

  task automatic rpl_wr(input logic [7:0] b, input int hold);
    snd_din = b;
    snd_wr  = 1'b1;
    cyc(hold);
    snd_wr  = 1'b0;
    cyc(2);
  endtask

  task automatic main_read(input int hold);
    main_rd = 1'b1;
    cyc(hold);
    main_rd = 1'b0;
    cyc(2);
  endtask

  // Monitor: whenever a read strobe starts while the DUT flags data present,
  // pop the next expected byte and compare; hold the command byte stable.
  logic       srd_prev = 1'b0, mrd_prev = 1'b0, cmd_act = 1'b0;
  logic [7:0] cmd_cur = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (snd_rd && !srd_prev) begin
        cmd_act = 1'b0;
        if (snd_obf) begin
          if (cmd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL cmd_unexpected: got %0h expected none", snd_dout);
          end else begin
            cmd_cur = cmd_q.pop_front();
            cmd_act = 1'b1;
            chk("cmd_pop", {24'd0, snd_dout}, {24'd0, cmd_cur});
          end
        end
      end else if (snd_rd && cmd_act) begin
        chk("cmd_stable", {24'd0, snd_dout}, {24'd0, cmd_cur});
      end
      if (!snd_rd) cmd_act = 1'b0;
      if (main_rd && !mrd_prev && main_st[1]) begin
        if (rply_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rply_unexpected: got %0h expected none", main_dout);
        end else begin
          chk("rply_pop", {24'd0, main_dout}, {24'd0, rply_q.pop_front()});
        end
      end
    end
    srd_prev = snd_rd;
    mrd_prev = main_rd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    cyc(3);
    chk("rst_st",   {29'd0, main_st}, 32'h0);
    chk("rst_obf",  {31'd0, snd_obf}, 32'h0);
    chk("rst_sdout", {24'd0, snd_dout}, 32'hff);
    chk("rst_mdout", {24'd0, main_dout}, 32'hff);
    rst = 1'b0;
    cyc(2);

    // Single command, held strobes
    main_din = 8'h81; main_wr = 1'b1; cmd_q.push_back(8'h81);
    cyc(2);
    chk("obf_after_push", {31'd0, snd_obf}, 32'h1);
    chk("sdout_after_push", {24'd0, snd_dout}, 32'h81);
    cyc(4); main_wr = 1'b0; cyc(2);
    chk("single_push_st", {29'd0, main_st}, 32'h0);
    snd_rd = 1'b1; cyc(4); snd_rd = 1'b0; cyc(2);
    chk("obf_after_pop", {31'd0, snd_obf}, 32'h0);
    chk("sdout_hold", {24'd0, snd_dout}, 32'h81);
    cyc(1);

    // Reply path
    rpl_wr(8'h5a, 3); rply_q.push_back(8'h5a);
    chk("rply_full", {29'd0, main_st}, 32'h2);
    chk("rply_dout", {24'd0, main_dout}, 32'h5a);
    main_read(3);
    chk("rply_clr", {29'd0, main_st}, 32'h0);
    rpl_wr(8'h5c, 2);
    rpl_wr(8'h5b, 2); rply_q.push_back(8'h5b);
    chk("rply_overwrite", {24'd0, main_dout}, 32'h5b);
    main_read(2);
    // Reply write coinciding with host read fall keeps the flag set
    main_rd = 1'b1; cyc(2);
    main_rd = 1'b0; snd_din = 8'h66; snd_wr = 1'b1; cyc(2);
    chk("rply_coincide", {31'd0, main_st[1]}, 32'h1);
    snd_wr = 1'b0; cyc(2); rply_q.push_back(8'h66);
    main_read(2);

    // Empty read
    rd_cmd(3);
    chk("empty_obf", {31'd0, snd_obf}, 32'h0);
    chk("empty_sdout", {24'd0, snd_dout}, 32'h81);
    chk("empty_st", {29'd0, main_st}, 32'h0);
    wr_cmd(8'ha5, 2, 1'b1);
    rd_cmd(2);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) wr_cmd(8'(i), 2, i <= 4);
    chk("fill_st", {29'd0, main_st}, 32'h5);
    chk("fill_obf", {31'd0, snd_obf}, 32'h1);
    for (int i = 0; i < 4; i++) rd_cmd(3);
    chk("drain_st", {29'd0, main_st}, 32'h4);
    chk("drain_obf", {31'd0, snd_obf}, 32'h0);

    // Reset mid-operation with main_wr held high
    wr_cmd(8'h21, 2, 1'b0);
    wr_cmd(8'h22, 2, 1'b0);
    wr_cmd(8'h23, 2, 1'b0);
    rpl_wr(8'h99, 2);
    main_din = 8'h77; main_wr = 1'b1; cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mid_rst_st", {29'd0, main_st}, 32'h0);
    chk("mid_rst_obf", {31'd0, snd_obf}, 32'h0);
    chk("mid_rst_sdout", {24'd0, snd_dout}, 32'hff);
    chk("mid_rst_mdout", {24'd0, main_dout}, 32'hff);
    cyc(3);
    chk("held_wr_no_push", {31'd0, snd_obf}, 32'h0);
    chk("held_wr_st", {29'd0, main_st}, 32'h0);
    main_wr = 1'b0; cyc(2);
    wr_cmd(8'h3c, 2, 1'b1);
    chk("post_rst_obf", {31'd0, snd_obf}, 32'h1);
    chk("post_rst_sdout", {24'd0, snd_dout}, 32'h3c);
    rd_cmd(3);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) wr_cmd(8'h10 + 8'(i), 2, 1'b1);
    chk("simul_pre_st", {29'd0, main_st}, 32'h1);
    snd_rd = 1'b1; cyc(3);
    snd_rd = 1'b0; main_din = 8'h14; main_wr = 1'b1; cmd_q.push_back(8'h14);
    cyc(2);
    chk("simul_st", {29'd0, main_st}, 32'h1);
    chk("simul_head", {24'd0, snd_dout}, 32'h11);
    main_wr = 1'b0; cyc(2);
    for (int i = 0; i < 4; i++) rd_cmd(3);
    chk("simul_drain_obf", {31'd0, snd_obf}, 32'h0);
    chk("simul_drain_st", {29'd0, main_st}, 32'h0);

    chk("cmd_q_drained", cmd_q.size(), 32'h0);
    chk("rply_q_drained", rply_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jts16b_sndlatch.md
JTS16B_SNDLATCH -- requirements
Module: jts16b_sndlatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth; power of two, 1..16; DEPTH=1 gives single-latch 315-5195 behaviour.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port main_wr  in  1  main CPU command write strobe, level, may stay high many clk cycles.
REQ-005 SHALL have port main_din  in  8  main CPU command byte, valid while main_wr high.
REQ-006 SHALL have port main_rd  in  1  main CPU reply read strobe, level.
REQ-007 SHALL have port main_dout  out  8  reply byte to main CPU.
REQ-008 SHALL have port main_st  out  3  status: {ovf, rply_full, cmd_full}.
REQ-009 SHALL have port snd_rd  in  1  sound CPU command read strobe, level (mapper_rd).
REQ-010 SHALL have port snd_wr  in  1  sound CPU reply write strobe, level (mapper_wr).
REQ-011 SHALL have port snd_din  in  8  sound CPU reply byte (mapper_din).
REQ-012 SHALL have port snd_dout  out  8  command byte to sound CPU (mapper_dout).
REQ-013 SHALL have port snd_obf  out  1  command pending; drives sound Z80 INT_n inverted.

Function
REQ-014 Each strobe SHALL be edge-detected against its value registered the previous clk; "rise" and "fall" refer to this.
REQ-015 A main_wr rise with FIFO not full SHALL write main_din at the write pointer and increment count, visible the next clk.
REQ-016 A main_wr rise with FIFO full SHALL drop the byte, leave FIFO unchanged, and set sticky ovf.
REQ-017 snd_dout SHALL be registered and equal the FIFO head while count>0.
REQ-018 Pop SHALL occur on snd_rd fall, not rise, so snd_dout stays stable for the whole Z80 read cycle.
REQ-019 A snd_rd fall with count=0 SHALL be ignored; snd_dout SHALL keep the last popped value.
REQ-020 After the last pop, snd_dout SHALL hold the popped byte until a new push; the next push SHALL appear on snd_dout one clk after the write.
REQ-021 snd_obf SHALL be registered, equal to (count!=0), and update one clk after the push or pop that changes count.
REQ-022 A push and a pop in the same clk SHALL both take effect; count SHALL be unchanged.
REQ-023 The same-clk push-and-pop rule SHALL also apply when full, so the push is accepted and ovf is not set.
REQ-024 cmd_full SHALL be (count==DEPTH), registered.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 count SHALL be one bit wider than the pointers.
REQ-027 An snd_wr rise SHALL load snd_din into the reply register and set rply_full, overwriting any unread reply.
REQ-028 main_dout SHALL always show the reply register.
REQ-029 A main_rd fall SHALL clear rply_full.
REQ-030 An snd_wr rise coinciding with a main_rd fall SHALL leave rply_full set.
REQ-031 ovf SHALL clear only on rst.
REQ-032 Strobes held high SHALL cause exactly one action per rise or fall, never one per clk.

Reset
REQ-033 While rst is high: pointers=0, count=0, snd_obf=0, snd_dout=8'hff, main_dout=8'hff, main_st=3'b000, edge-detect registers=0.
REQ-034 A strobe already high when rst releases SHALL NOT produce a rise.
REQ-035 Reset asserted mid-transfer SHALL discard all FIFO contents and the reply; the first post-reset push SHALL land in slot 0.

Verification
REQ-036 Single command: main_wr high 6 clk with 8'h81 -> snd_obf=1 two clk after the rise, snd_dout=8'h81; snd_rd high 4 clk -> snd_obf=0 two clk after the fall, snd_dout remains 8'h81.
REQ-037 Fill and overflow, DEPTH=4: push 8'h01..8'h05 -> cmd_full=1, ovf=1; pops return 01,02,03,04 in order; snd_obf=0 after the 4th pop.
REQ-038 Simultaneous: FIFO holds 8'h10, 8'h11 (full at DEPTH=2); main_wr rise of 8'h12 in the same clk as snd_rd fall -> count stays 2, ovf=0, head becomes 8'h11.
REQ-039 Reply path: snd_wr with 8'h5a -> main_st[1]=1, main_dout=8'h5a; main_rd pulse -> main_st[1]=0 after the fall; second snd_wr of 8'h5b before the read -> main_dout=8'h5b.
REQ-040 Empty read: snd_rd pulse with count=0 -> count stays 0, snd_obf=0, pointers unchanged, snd_dout unchanged.
REQ-041 Reset mid-operation: 3 bytes queued, ovf=1, rst for 1 clk while main_wr held high -> all outputs at reset values; no push until main_wr falls and rises again.
